// File: rtl/clock_divider.sv
// Multi-channel programmable clock divider with shadowed, glitch-free ratio reload.
// Define CLKDIV_CNT_OUT_EN to expose the per-channel counters on cnt_out.
module clock_divider #(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [DIV_W-1:0]       cfg_div,
    input  logic                   cfg_sync,
    output logic [N_CH-1:0]        clk_out,
    output logic [N_CH-1:0]        tick,
    output logic [N_CH-1:0]        pend
`ifdef CLKDIV_CNT_OUT_EN
    ,
    output logic [N_CH*DIV_W-1:0]  cnt_out
`endif
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt_q    [N_CH];
    logic [DIV_W-1:0] div_q    [N_CH];
    logic [DIV_W-1:0] shadow_q [N_CH];
    logic [DIV_W-1:0] cnt_nxt  [N_CH];
    logic [DIV_W-1:0] div_nxt  [N_CH];
    logic [N_CH-1:0]  reload;
    logic [N_CH-1:0]  wr_hit;
    logic [DIV_W-1:0] wr_val;

    // cfg_sync overrides the normal step; a channel only reloads when it has a pending ratio.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_val = (cfg_div < TWO) ? TWO : cfg_div;
        wr_hit = '0;
        reload = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt_q[i];
            div_nxt[i] = div_q[i];
            // An out-of-range cfg_ch matches no channel, so the write is dropped.
            wr_hit[i]  = cfg_we && (int'(cfg_ch) == i);
            if (cfg_sync) begin
                cnt_nxt[i] = '0;
                reload[i]  = pend[i];
            end else if (en) begin
                if (cnt_q[i] == div_q[i] - ONE) begin
                    cnt_nxt[i] = '0;
                    reload[i]  = pend[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + ONE;
                end
            end
            if (reload[i]) div_nxt[i] = shadow_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset like any register.
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= DEF - ONE;
                div_q[i]    <= DEF;
                shadow_q[i] <= DEF;
            end
            clk_out <= '0;
            tick    <= '0;
            pend    <= '0;
        end else begin
            // NOTE: non-blocking assignments, so the reload reads shadow_q before a same-cycle write lands.
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_nxt[i];
                div_q[i] <= div_nxt[i];
                if (cfg_sync || en) clk_out[i] <= (cnt_nxt[i] < (div_nxt[i] >> 1));
                tick[i] <= en && (cnt_nxt[i] == '0);
                if (reload[i]) pend[i] <= 1'b0;
                if (wr_hit[i]) begin
                    shadow_q[i] <= wr_val;
                    pend[i]     <= 1'b1;
                end
            end
        end
    end

`ifdef CLKDIV_CNT_OUT_EN
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < N_CH; i++) cnt_out[i*DIV_W +: DIV_W] = cnt_q[i];
    end
`endif

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Synthesisable, multi-channel programmable clock divider; successor to the simulation-only clock source.
- From one system clock, produces N_CH independent divided clock levels plus aligned single-cycle tick strobes for CPU peripherals (timers, UART baud, debug LEDs).
- Divide ratios are written at run time through a simple write port and take effect glitch-free at the next period boundary.

Parameters:
- N_CH, 2, number of output channels (1..8).
- DIV_W, 16, width of divide ratio and per-channel counter.
- DEFAULT_DIV, 2, divide ratio loaded into every channel at reset (>= 2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global run enable; 0 freezes all channels.
- cfg_we  in  1  one-cycle write strobe for a divide ratio.
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel of the write.
- cfg_div  in  DIV_W  new divide ratio N.
- cfg_sync  in  1  restart all channels in phase.
- clk_out  out  N_CH  divided clock levels, registered.
- tick  out  N_CH  one-cycle pulse in the cycle each clk_out rises.
- pend  out  N_CH  channel has a written ratio not yet applied.
- cnt_out  out  N_CH*DIV_W  current counters (only with CLKDIV_CNT_OUT_EN).

Behaviour:
- Reset (async, rst_n=0):
  - per channel: div=DEFAULT_DIV, shadow=DEFAULT_DIV, cnt=DEFAULT_DIV-1.
  - outputs: clk_out=0, tick=0, pend=0, cnt_out=cnt.
- Channel step (en=1, each clk): cnt_next = (cnt==div-1) ? 0 : cnt+1.
- Registered outputs, all updated from cnt_next in the same edge as cnt, so clk_out and tick rise together:
  - clk_out <= (cnt_next < div>>1).
  - tick <= (cnt_next==0).
- Duty cycle:
  - clk_out high for floor(N/2) cycles, low for ceil(N/2) cycles.
  - Period exactly N cycles; odd N gives the extra cycle low.
- First enabled edge after reset wraps cnt to 0: clk_out=1, tick=1.
- en=0:
  - cnt, div and clk_out hold; tick forced 0 next edge.
  - Writes and cfg_sync still accepted.
- Write (cfg_we=1):
  - shadow[cfg_ch] <= max(cfg_div, 2); pend[cfg_ch] <= 1.
  - cfg_div of 0 or 1 is clamped to 2.
  - cfg_ch >= N_CH: write ignored, no state change.
- Reload:
  - At a wrap (en=1, cnt==div-1) with pend=1: div <= shadow, pend <= 0.
  - The new period starts at that wrap; no runt pulse.
- Write in the same cycle as a wrap on that channel:
  - The wrap applies the old shadow if pend was set; otherwise div is unchanged.
  - The new value lands in shadow with pend=1, applied at the following wrap.
- cfg_sync=1 (takes precedence over normal step/wrap):
  - All channels apply shadow if pend (pend cleared), then cnt <= 0.
  - If en=1: clk_out <= 1, tick <= 1.
  - If en=0: cnt <= 0 and clk_out <= 1, tick stays 0; the first enabled edge then advances cnt to 1.
  - A cfg_we in the same cycle as cfg_sync is written to shadow after the sync apply; it stays pending.
- Counter arithmetic unsigned DIV_W bits; max ratio 2^DIV_W-1; no overflow possible since cnt < div.
- Reset mid-period: immediate return to reset values; pending writes discarded.

Optional Feature:
- CLKDIV_CNT_OUT_EN
  - Defined: port cnt_out present, channel i counter on bits [i*DIV_W +: DIV_W], combinational copy of cnt.
  - Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then en=1, N_CH=2, DEFAULT_DIV=2 -> both clk_out toggle every cycle, tick high every 2nd cycle starting first edge, pend=0.
- Write ch0 div=5 mid-period -> pend[0]=1 until wrap; afterwards clk_out[0] high 2, low 3, tick every 5 cycles; ch1 unaffected.
- Write div=1 then div=0 to ch1 -> both clamped: ch1 period 2; write cfg_ch=3 with N_CH=2 -> no change, pend unchanged.
- ch0 div=4 and ch1 div=6 running, pulse cfg_sync -> next edge both clk_out=1 and tick=11; thereafter ticks coincide every 12 cycles.
- en=0 for 7 cycles mid-high-phase -> clk_out held, tick=0, cnt frozen; en=1 resumes with the remaining phase length unchanged.
- Write ch0 div=8 on exact wrap cycle while pend=0 -> current period keeps old div, pend=1, new div active from the following wrap; assert rst_n=0 mid-period -> all outputs 0 immediately.
